// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared bus types and loader FSM states for the boot ROM loader.
package rom_loader_pkg;
    typedef logic [31:0] mem_addr_t;
    typedef logic [31:0] word_t;
    typedef logic [7:0]  byte_t;
    localparam word_t ZERO_WORD = 32'h0000_0000;
    typedef enum logic [2:0] {IDLE, LEN, DATA, DONE, ERR} state_t;
endpackage

// File: rtl/rom_loader_byte_packer.sv
// rom_byte_packer: merges stream bytes into little-endian words and registers
// one byte-selected ROM write when a word completes or the payload ends.
module rom_byte_packer
    import rom_loader_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    input  logic      push,
    input  byte_t     data,
    input  logic [1:0] lane,
    input  logic      last,
    input  mem_addr_t addr,
    output logic      w_en,
    output mem_addr_t w_addr,
    output word_t     w_data,
    output logic [3:0] w_sel
);
    word_t      acc, merged;
    logic [3:0] sel, merged_sel;
    logic       flush;
    assign merged     = acc | (word_t'(data) << {lane, 3'b000});
    assign merged_sel = sel | (4'b0001 << lane);
    assign flush      = push && (lane == 2'd3 || last);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= ZERO_WORD;
            sel    <= '0;
            w_en   <= 1'b0;
            w_addr <= '0;
            w_data <= ZERO_WORD;
            w_sel  <= '0;
        end else begin
            w_en <= flush;
            if (flush) begin
                w_addr <= addr;
                w_data <= merged;
                w_sel  <= merged_sel;
            end
            // Flushing clears the buffer in the same cycle so the next word starts empty.
            acc <= (clr || flush) ? ZERO_WORD : push ? merged : acc;
            sel <= (clr || flush) ? 4'b0000 : push ? merged_sel : sel;
        end
    end
endmodule

// File: rtl/rom_loader.sv
// rom_loader: length-prefixed byte stream to ROM word writes, holding the core
// in reset until the final write has landed.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter mem_addr_t   BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_LEN        = 65536,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       byte_valid_i,
    input  byte_t      byte_data_i,
    output logic       byte_ready_o,
    output logic       w_en_o,
    output mem_addr_t  w_addr_o,
    output word_t      w_data_o,
    output logic [3:0] w_sel_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       cpu_rst_n_o
);
    state_t      state, next;
    logic [31:0] cnt, len, timer, len_full;
    logic        xfer, push, last, fin, tout, restart;
    assign xfer     = byte_valid_i & byte_ready_o;
    assign push     = xfer && state == DATA;
    assign len_full = {byte_data_i, len[31:8]};
    assign last     = cnt == len - 32'd1;
    assign restart  = start_i && state inside {IDLE, DONE, ERR};
    // fin marks the cycle the final write is on the bus; no timeout applies there.
    assign tout     = !xfer && !fin && timer + 32'd1 == TIMEOUT_CYCLES;
    always_comb begin
        next = state;
        case (state)
            IDLE, DONE, ERR: next = start_i ? LEN : state;
            LEN: begin
                if (xfer && cnt == 32'd3)
                    next = len_full == 32'd0 ? DONE : len_full > MAX_LEN ? ERR : DATA;
                else if (tout)
                    next = ERR;
            end
            DATA:    next = fin ? DONE : tout ? ERR : DATA;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            len          <= '0;
            timer        <= '0;
            fin          <= 1'b0;
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            cpu_rst_n_o  <= 1'b0;
        end else begin
            state        <= next;
            fin          <= push && last;
            byte_ready_o <= next == LEN || (next == DATA && !(push && last));
            busy_o       <= next inside {LEN, DATA};
            done_o       <= next == DONE;
            err_o        <= next == ERR;
            cpu_rst_n_o  <= next == DONE;
            if (restart) begin
                cnt   <= '0;
                len   <= '0;
                timer <= '0;
            end else if (xfer) begin
                cnt   <= (state == LEN && cnt == 32'd3) ? 32'd0 : cnt + 32'd1;
                len   <= state == LEN ? len_full : len;
                timer <= '0;
            end else if (state inside {LEN, DATA}) begin
                timer <= timer + 32'd1;
            end
        end
    end
    rom_byte_packer u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (restart),
        .push   (push),
        .data   (byte_data_i),
        .lane   (cnt[1:0]),
        .last   (last),
        .addr   (BASE_ADDR + {cnt[31:2], 2'b00}),
        .w_en   (w_en_o),
        .w_addr (w_addr_o),
        .w_data (w_data_o),
        .w_sel  (w_sel_o)
    );
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: scoreboard bench; expected ROM writes are queued as streams
// are driven and compared against writes observed on the ROM port.
module tb_rom_loader;
    localparam int TO = 20;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        byte_ready_o, w_en_o, busy_o, done_o, err_o, cpu_rst_n_o;
    logic [31:0] w_addr_o, w_data_o;
    logic [3:0]  w_sel_o;
    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    wr_t         obs_q[$];
    logic [7:0]  pl[$];

    rom_loader #(.BASE_ADDR(32'h0), .MAX_LEN(65536), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
        .w_en_o(w_en_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o), .w_sel_o(w_sel_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .cpu_rst_n_o(cpu_rst_n_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (w_en_o) obs_q.push_back('{w_addr_o, w_data_o, w_sel_o});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        byte_valid_i = 1'b0;
        step(gap);
        byte_valid_i = 1'b1;
        byte_data_i = b;
        while (!byte_ready_o && n < 100) begin step(1); n++; end
        check("ready_wait", 32'(n < 100), 32'd1);
        step(1);
        byte_valid_i = 1'b0;
    endtask

    task automatic expect_words(input logic [7:0] p[$], input int n);
        for (int w = 0; w < (n + 3) / 4; w++) begin
            wr_t e = '{32'(w * 4), 32'h0, 4'h0};
            for (int j = 0; j < 4; j++)
                if (w * 4 + j < n) begin
                    e.d[8*j +: 8] = p[w*4+j];
                    e.s[j] = 1'b1;
                end
            exp_q.push_back(e);
        end
    endtask

    task automatic load(input logic [7:0] p[$], input int gapmax);
        logic [31:0] l = 32'(p.size());
        expect_words(p, p.size());
        for (int i = 0; i < 4; i++) send(l[8*i +: 8], 0);
        foreach (p[i]) send(p[i], gapmax == 0 ? 0 : int'($urandom_range(gapmax, 0)));
    endtask

    task automatic drain(input string tag);
        while (obs_q.size() > 0) begin
            wr_t o = obs_q.pop_front();
            if (exp_q.size() == 0) check({tag, "_unexpected_write"}, o.a, 32'hFFFF_FFFF);
            else begin
                wr_t e = exp_q.pop_front();
                check({tag, "_addr"}, o.a, e.a);
                check({tag, "_data"}, o.d, e.d);
                check({tag, "_sel"}, 32'(o.s), 32'(e.s));
            end
        end
        check({tag, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #3;
        check("reset_ctrl", {22'b0, byte_ready_o, w_en_o, w_sel_o, busy_o, done_o, err_o, cpu_rst_n_o}, 32'h0);
        check("reset_addr", w_addr_o, 32'h0);
        check("reset_data", w_data_o, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // basic 5-byte load, back-to-back
        pulse_start();
        check("t1_busy", 32'(busy_o), 32'd1);
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        load(pl, 0);
        check("t1_wen_last", 32'(w_en_o), 32'd1);
        check("t1_ready_drop", 32'(byte_ready_o), 32'd0);
        check("t1_cpu_held", 32'(cpu_rst_n_o), 32'd0);
        step(1);
        check("t1_cpu_release", 32'(cpu_rst_n_o), 32'd1);
        check("t1_done", 32'(done_o), 32'd1);
        check("t1_wen_off", 32'(w_en_o), 32'd0);
        drain("t1");

        // zero-length load
        pulse_start();
        check("t2_done_cleared", 32'(done_o), 32'd0);
        check("t2_cpu_held", 32'(cpu_rst_n_o), 32'd0);
        pl = {};
        load(pl, 0);
        check("t2_done", 32'(done_o), 32'd1);
        check("t2_cpu", 32'(cpu_rst_n_o), 32'd1);
        step(3);
        drain("t2");

        // oversize length
        pulse_start();
        send(8'h01, 0); send(8'h00, 0); send(8'h01, 0); send(8'h00, 0);
        check("t3_err", 32'(err_o), 32'd1);
        check("t3_cpu", 32'(cpu_rst_n_o), 32'd0);
        byte_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_no_ready", 32'(byte_ready_o), 32'd0);
            step(1);
        end
        byte_valid_i = 1'b0;
        drain("t3");

        // timeout after payload byte 6 of 8, then reload
        pulse_start();
        check("t4_err_cleared", 32'(err_o), 32'd0);
        pl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        expect_words(pl, 4);
        send(8'h08, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        foreach (pl[i]) send(pl[i], 0);
        step(TO + 5);
        check("t4_err", 32'(err_o), 32'd1);
        check("t4_busy", 32'(busy_o), 32'd0);
        check("t4_cpu", 32'(cpu_rst_n_o), 32'd0);
        drain("t4");
        pulse_start();
        pl = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
        load(pl, 0);
        step(2);
        check("t4_reload_done", 32'(done_o), 32'd1);
        drain("t4r");

        // 64 random bytes with random gaps below the timeout
        pulse_start();
        pl = {};
        for (int i = 0; i < 64; i++) pl.push_back(8'($urandom));
        load(pl, 5);
        step(2);
        check("t5_done", 32'(done_o), 32'd1);
        check("t5_write_count", 32'(obs_q.size()), 32'd16);
        drain("t5");

        // async reset mid-word
        pulse_start();
        send(8'h04, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'hC0, 0); send(8'hC1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_ctrl", {22'b0, byte_ready_o, w_en_o, w_sel_o, busy_o, done_o, err_o, cpu_rst_n_o}, 32'h0);
        check("t6_addr", w_addr_o, 32'h0);
        check("t6_data", w_data_o, 32'h0);
        step(3);
        rst_n = 1'b1;
        step(3);
        check("t6_idle_ready", 32'(byte_ready_o), 32'd0);
        drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time writer for the instruction/data ROM's single write port. Receives a length-prefixed byte stream from the UART receiver over a valid/ready handshake, packs bytes little-endian into 32-bit words, and issues byte-selected word writes starting at `BASE_ADDR`. While loading, the core is held in reset; the core is released only after the final write completes.

## Interface
- `BASE_ADDR`, 32'h0000_0000: first write address; must be word aligned.
- `MAX_LEN`, 65536: largest accepted payload in bytes (ROM depth × 4).
- `TIMEOUT_CYCLES`, 1_000_000: idle cycles allowed between bytes before abort; must be ≥ 1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  single-cycle request to begin a load.
- `byte_valid_i`  in  1  stream byte present.
- `byte_data_i`  in  8  stream byte.
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `w_en_o`  out  1  ROM write strobe, one cycle per word.
- `w_addr_o`  out  `MemAddrBus`  word-aligned byte address.
- `w_data_o`  out  `WordBus`  write data; unselected lanes are zero.
- `w_sel_o`  out  4  byte-lane enables; bit n covers bits [8n+7:8n].
- `busy_o`  out  1  in LEN or DATA.
- `done_o`  out  1  last load completed.
- `err_o`  out  1  last load aborted.
- `cpu_rst_n_o`  out  1  active-low core reset; 1 only in DONE.

## Operation
- A byte transfers on any cycle where `byte_valid_i` and `byte_ready_o` are both 1. `byte_ready_o` is 1 exactly in LEN and DATA; the loader never stalls mid-load.
- Stream format: 4 length bytes L (little-endian, LSB first), then L payload bytes. Payload byte k goes to address `BASE_ADDR + k`, lane k[1:0].
- States: IDLE, LEN, DATA, DONE, ERR.
- IDLE/DONE/ERR: `start_i` → LEN. This clears the byte counter, length, assembly buffer and timer, drops `done_o`/`err_o`, and drives `cpu_rst_n_o` to 0.
- LEN: after the 4th byte, L = 0 → DONE; L > `MAX_LEN` → ERR; otherwise → DATA.
- DATA: each byte is merged into the assembly buffer, and its lane bit is set in a pending select. On lane 3, or on the last payload byte (k = L−1), the merged word and select are registered to the write outputs, and the buffer and select are cleared in the same cycle. After the last write → DONE.
- A partial final word carries only its valid lanes (for example L = 5 → second write has `w_sel_o` = 4'b0001).
- Timeout: in LEN or DATA, the timer counts cycles without a transfer and resets on every transfer. When it reaches `TIMEOUT_CYCLES` → ERR. Words already written stay written.
- `start_i` in LEN or DATA is ignored.
- `start_i` in the same cycle as the final write keeps the write and still enters DONE. A later `start_i` is required to reload.

## Timing
- `rst_n` low: state IDLE; `byte_ready_o`, `w_en_o`, `w_sel_o`, `busy_o`, `done_o`, `err_o`, `cpu_rst_n_o` are 0; `w_addr_o`, `w_data_o` are 0.
- Reset asserted mid-load aborts immediately with no further writes.
- All outputs are registered.
- `w_en_o` is high for exactly the one cycle after the transfer that completes a word.
- Back-to-back bytes give a sustained rate of one write every 4 cycles, with no bubbles.
- DONE is entered, and `cpu_rst_n_o` rises, in the cycle after the final `w_en_o` pulse, so the ROM contents are stable before the core leaves reset.
- The ERR transition occurs on the cycle the timer reaches `TIMEOUT_CYCLES`. `byte_ready_o` drops in that same transition.
- Byte counter and length are 32-bit.
- `w_addr_o` = `BASE_ADDR` + {k[31:2], 2'b00}. It wraps modulo 2^32, which cannot occur when `MAX_LEN` is in range.

## Structure
- Shared `buceros_header.v` supplies `MemAddrBus`, `WordBus` and `ZeroWord`, and gains a `ByteBus` (7:0) define.
- State encodings are module-local localparams.
- One sub-module is natural: `rom_byte_packer`. It holds the lane buffer, pending select, and the word-complete/flush logic.
- The FSM, counters and timer stay in `rom_loader`.

## Test plan
- Header 05 00 00 00, payload 11 22 33 44 55 streamed back-to-back → write 0x00: data 0x44332211, sel 1111; write 0x04: data 0x00000055, sel 0001; `cpu_rst_n_o` rises one cycle after the second write.
- Header 00 00 00 00 → no `w_en_o`; DONE with `done_o` = 1 immediately after the 4th byte.
- L = `MAX_LEN`+1 → `err_o` = 1; `cpu_rst_n_o` stays 0; no writes; subsequent bytes not accepted.
- L = 8 with a gap of `TIMEOUT_CYCLES` after byte 6 → exactly one write (at 0x00); `err_o` = 1; a fresh `start_i` plus a full stream yields a correct reload.
- Random `byte_valid_i` gaps shorter than the timeout, L = 64 → 16 writes, addresses 0x00..0x3C, data matches the stream.
- `rst_n` asserted after payload byte 2 → all outputs 0 asynchronously; no write issued for the partial word.
